pc_sequencer: RTL and testbench

// Parametrised program-counter sequencer for the core fetch stage, replacing the fixed 10-bit step-only PC.

---
 rtl/pc_sequencer_pkg.sv | 26 ++
 rtl/pc_sequencer_if.sv | 31 +++
 rtl/pc_sequencer_ras.sv | 50 +++++
 rtl/pc_sequencer.sv | 112 +++++++++++
 tb/tb_pc_sequencer.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared defaults and next-PC source encoding for the fetch-stage PC sequencer.
// The priority function below is the single place that decides which source feeds the PC.
package pc_sequencer_pkg;

  localparam int DEF_ADDR_W     = 10;
  localparam int DEF_ALIGN_BITS = 2;
  localparam int DEF_RESET_VEC  = 0;
  localparam int DEF_RAS_DEPTH  = 4;

  localparam logic [2:0] SEL_CALL = 3'd0;
  localparam logic [2:0] SEL_JUMP = 3'd1;
  localparam logic [2:0] SEL_POP  = 3'd2;
  localparam logic [2:0] SEL_UNF  = 3'd3;
  localparam logic [2:0] SEL_STEP = 3'd4;

  // Redirect beats return; a lone call with no redirect is just a step.
  function automatic logic [2:0] pc_select(input logic redirect_en, input logic call,
                                           input logic ret, input logic ras_empty);
    if (redirect_en && call) return SEL_CALL;
    if (redirect_en)         return SEL_JUMP;
    if (ret && !ras_empty)   return SEL_POP;
    if (ret)                 return SEL_UNF;
    return SEL_STEP;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control and status bundle between the fetch controller (master) and the PC sequencer (slave).
import pc_sequencer_pkg::*;

// nxt is a level; only its rising edge requests a step. start pulses for exactly one cycle
// in the cycle addr shows its new value; there is no back-pressure on start.
interface pc_sequencer_if #(parameter int ADDR_W = DEF_ADDR_W);
  logic              nxt;
  logic              run_en;
  logic              stall;
  logic              redirect_en;
  logic [ADDR_W-1:0] redirect_pc;
  logic              call;
  logic              ret;
  logic              clr_err;
  logic [ADDR_W-1:0] addr;
  logic              start;
  logic              misalign_err;
  logic              ras_ovf;
  logic              ras_unf;
  logic              ras_empty;

  modport master (
    output nxt, run_en, stall, redirect_en, redirect_pc, call, ret, clr_err,
    input  addr, start, misalign_err, ras_ovf, ras_unf, ras_empty
  );

  modport slave (
    input  nxt, run_en, stall, redirect_en, redirect_pc, call, ret, clr_err,
    output addr, start, misalign_err, ras_ovf, ras_unf, ras_empty
  );
endinterface

// File: rtl/pc_sequencer_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry.
// Push and pop are never requested together by the sequencer.
module pc_sequencer_ras #(
  parameter int DEPTH = 4,
  parameter int W = 10,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [W-1:0]     data_i,
  output logic [W-1:0]     data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] top_idx;
  logic [PTR_W-1:0] ptr_inc;
  logic [CNT_W-1:0] cnt_q;

  // ptr_q is the next write slot; the newest entry sits just below it.
  assign top_idx = (ptr_q == '0) ? PTR_W'(DEPTH - 1) : ptr_q - PTR_W'(1);
  assign ptr_inc = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);

  assign data_o  = mem_q[top_idx];
  assign count_o = cnt_q;
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_i) begin
      mem_q[ptr_q] <= data_i;
      ptr_q        <= ptr_inc;
      if (!full_o) cnt_q <= cnt_q + CNT_W'(1);
    end else if (pop_i && !empty_o) begin
      ptr_q <= top_idx;
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: edge-detected single step or free run, stall with one held
// step, redirect/call/return through a return-address stack, and sticky error flags.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int ALIGN_BITS = DEF_ALIGN_BITS,
  parameter int RESET_VEC  = DEF_RESET_VEC,
  parameter int RAS_DEPTH  = DEF_RAS_DEPTH
) (
  input logic           clk,
  input logic           rst,
  pc_sequencer_if.slave pc_bus
);

  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(1 << ALIGN_BITS);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << ALIGN_BITS) - 1);
  localparam int                CNT_W      = $clog2(RAS_DEPTH + 1);

  logic              nxt_q;
  logic              pending_q, pending_d;
  logic              start_q, start_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              misalign_q, misalign_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              step_edge;
  logic              adv;
  logic [2:0]        sel;
  logic [ADDR_W-1:0] addr_inc;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_push, ras_pop, ras_full, ras_empty;
  logic [CNT_W-1:0]  ras_count;

  assign step_edge = pc_bus.nxt & ~nxt_q;
  assign adv       = ~pc_bus.stall & (pc_bus.run_en | step_edge | pending_q);
  // A stall holds at most one step request, however many edges arrive meanwhile.
  assign pending_d = (pending_q | step_edge) & pc_bus.stall;

  assign addr_inc = addr_q + STEP;
  assign target   = pc_bus.redirect_pc & ~ALIGN_MASK;
  assign sel      = pc_select(pc_bus.redirect_en, pc_bus.call, pc_bus.ret, ras_empty);
  assign ras_push = adv && (sel == SEL_CALL);
  assign ras_pop  = adv && (sel == SEL_POP);

  pc_sequencer_ras #(.DEPTH(RAS_DEPTH), .W(ADDR_W)) u_ras (
    .clk     (clk),
    .rst     (rst),
    .push_i  (ras_push),
    .pop_i   (ras_pop),
    .data_i  (addr_inc),
    .data_o  (ras_top),
    .count_o (ras_count),
    .full_o  (ras_full),
    .empty_o (ras_empty)
  );

  // Flag-setting events are ORed in after the clear so they win over clr_err.
  always_comb begin
    addr_d     = addr_q;
    start_d    = adv;
    misalign_d = misalign_q & ~pc_bus.clr_err;
    ovf_d      = ovf_q & ~pc_bus.clr_err;
    unf_d      = unf_q & ~pc_bus.clr_err;
    if (adv) begin
      case (sel)
        SEL_CALL: begin
          addr_d = target;
          if (ras_full) ovf_d = 1'b1;
        end
        SEL_JUMP: addr_d = target;
        SEL_POP:  addr_d = ras_top;
        SEL_UNF: begin
          addr_d = addr_inc;
          unf_d  = 1'b1;
        end
        default:  addr_d = addr_inc;
      endcase
      if (((sel == SEL_CALL) || (sel == SEL_JUMP)) && |(pc_bus.redirect_pc & ALIGN_MASK))
        misalign_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nxt_q      <= 1'b0;
      pending_q  <= 1'b0;
      start_q    <= 1'b0;
      addr_q     <= ADDR_W'(RESET_VEC);
      misalign_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      nxt_q      <= pc_bus.nxt;
      pending_q  <= pending_d;
      start_q    <= start_d;
      addr_q     <= addr_d;
      misalign_q <= misalign_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  assign pc_bus.addr         = addr_q;
  assign pc_bus.start        = start_q;
  assign pc_bus.misalign_err = misalign_q;
  assign pc_bus.ras_ovf      = ovf_q;
  assign pc_bus.ras_unf      = unf_q;
  assign pc_bus.ras_empty    = (ras_count == '0);

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: expected PCs are queued as each step is requested and popped
// when the start pulse appears; a small RAS model supplies return targets.
module tb_pc_sequencer;
  localparam int                ADDR_W = 10;
  localparam logic [ADDR_W-1:0] STEP   = 10'd4;

  logic clk;
  logic rst;
  int   n_compared;
  int   n_mismatched;
  logic [ADDR_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] ras_m[$];
  logic [ADDR_W-1:0] exp_addr;

  pc_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  pc_sequencer #(.ADDR_W(ADDR_W), .ALIGN_BITS(2), .RESET_VEC(0), .RAS_DEPTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .pc_bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  function automatic logic [3:0] flags();
    return {bus.misalign_err, bus.ras_ovf, bus.ras_unf, bus.ras_empty};
  endfunction

  task automatic drive_idle();
    bus.nxt = 0; bus.run_en = 0; bus.stall = 0; bus.redirect_en = 0;
    bus.redirect_pc = '0; bus.call = 0; bus.ret = 0; bus.clr_err = 0;
  endtask

  task automatic wait_start(input int budget, output bit seen);
    seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.start === 1'b1) begin
        seen = 1;
        break;
      end
    end
  endtask

  // One nxt pulse; returns one cycle after the advance with nxt low again.
  task automatic step(output bit seen);
    bus.nxt = 1;
    wait_start(4, seen);
    bus.nxt = 0;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1;
    drive_idle();
    repeat (2) @(negedge clk);
    n_compared++;
    if (bus.addr !== 10'h000) begin n_mismatched++; $display("FAIL reset_addr: got %h expected 000", bus.addr); end
    n_compared++;
    if (bus.start !== 1'b0) begin n_mismatched++; $display("FAIL reset_start: got %b expected 0", bus.start); end
    n_compared++;
    if (flags() !== 4'b0001) begin n_mismatched++; $display("FAIL reset_flags: got %b expected 0001", flags()); end
    rst = 0;
    repeat (2) @(negedge clk);
    n_compared++;
    if (bus.addr !== 10'h000 || bus.start !== 1'b0) begin
      n_mismatched++; $display("FAIL idle_after_reset: addr %h start %b expected 000/0", bus.addr, bus.start);
    end
    exp_addr = '0;
  endtask

  task automatic test_step();
    bit seen;
    int n_adv;
    logic [ADDR_W-1:0] got, last;
    for (int i = 0; i < 3; i++) begin
      exp_addr = exp_addr + STEP;
      exp_q.push_back(exp_addr);
      bus.nxt = 1;
      wait_start(4, seen);
      got = exp_q.pop_front();
      n_compared++;
      if (!seen || bus.addr !== got) begin
        n_mismatched++; $display("FAIL step_addr[%0d]: got %h start_seen %0d expected %h", i, bus.addr, seen, got);
      end
      @(negedge clk);
      n_compared++;
      if (bus.start !== 1'b0) begin n_mismatched++; $display("FAIL step_start_width[%0d]: got %b expected 0", i, bus.start); end
      bus.nxt = 0;
      @(negedge clk);
    end
    exp_addr = exp_addr + STEP;
    exp_q.push_back(exp_addr);
    bus.nxt = 1;
    n_adv = 0;
    last = '0;
    repeat (10) begin
      @(negedge clk);
      if (bus.start === 1'b1) begin n_adv++; last = bus.addr; end
    end
    bus.nxt = 0;
    @(negedge clk);
    got = exp_q.pop_front();
    n_compared++;
    if (n_adv != 1 || last !== got) begin
      n_mismatched++; $display("FAIL held_nxt: advances %0d addr %h expected 1 advance to %h", n_adv, last, got);
    end
  endtask

  task automatic test_run_wrap();
    bit seen;
    logic [ADDR_W-1:0] got;
    bus.redirect_en = 1; bus.redirect_pc = 10'h3F8;
    exp_addr = 10'h3F8;
    exp_q.push_back(exp_addr);
    step(seen);
    bus.redirect_en = 0;
    got = exp_q.pop_front();
    n_compared++;
    if (!seen || bus.addr !== got) begin n_mismatched++; $display("FAIL jump_3f8: got %h expected %h", bus.addr, got); end
    for (int i = 0; i < 2; i++) begin
      exp_addr = exp_addr + STEP;
      exp_q.push_back(exp_addr);
    end
    bus.run_en = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      got = exp_q.pop_front();
      n_compared++;
      if (bus.start !== 1'b1 || bus.addr !== got) begin
        n_mismatched++; $display("FAIL run_addr[%0d]: got %h start %b expected %h/1", i, bus.addr, bus.start, got);
      end
    end
    // Stalled while every control that could move the PC or set a flag is asserted.
    bus.stall = 1; bus.redirect_en = 1; bus.redirect_pc = 10'h003; bus.call = 1; bus.ret = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_compared++;
      if (bus.start !== 1'b0 || bus.addr !== exp_addr) begin
        n_mismatched++; $display("FAIL stall_hold[%0d]: got %h start %b expected %h/0", i, bus.addr, bus.start, exp_addr);
      end
    end
    n_compared++;
    if (flags() !== 4'b0001) begin n_mismatched++; $display("FAIL stall_flags: got %b expected 0001", flags()); end
    bus.run_en = 0; bus.redirect_en = 0; bus.call = 0; bus.ret = 0;
    @(negedge clk);
    bus.stall = 0;
    @(negedge clk);
  endtask

  task automatic test_stall_pending();
    int n_adv;
    logic [ADDR_W-1:0] got;
    bit pat [5];
    pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    bus.stall = 1;
    for (int i = 0; i < 5; i++) begin
      bus.nxt = pat[i];
      @(negedge clk);
      n_compared++;
      if (bus.start !== 1'b0) begin n_mismatched++; $display("FAIL pend_stalled[%0d]: start %b expected 0", i, bus.start); end
    end
    exp_addr = exp_addr + STEP;
    exp_q.push_back(exp_addr);
    bus.stall = 0;
    @(negedge clk);
    got = exp_q.pop_front();
    n_compared++;
    if (bus.start !== 1'b1 || bus.addr !== got) begin
      n_mismatched++; $display("FAIL pend_release: got %h start %b expected %h/1", bus.addr, bus.start, got);
    end
    n_adv = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.start === 1'b1) n_adv++;
    end
    n_compared++;
    if (n_adv != 0) begin n_mismatched++; $display("FAIL pend_single: extra advances %0d expected 0", n_adv); end
    bus.nxt = 0;
    @(negedge clk);
  endtask

  task automatic test_call_ret();
    bit seen;
    logic [ADDR_W-1:0] got;
    bus.redirect_en = 1; bus.redirect_pc = 10'h010;
    exp_addr = 10'h010; exp_q.push_back(exp_addr);
    step(seen);
    bus.redirect_en = 0;
    got = exp_q.pop_front();
    n_compared++;
    if (!seen || bus.addr !== got) begin n_mismatched++; $display("FAIL jump_010: got %h expected %h", bus.addr, got); end
    bus.redirect_en = 1; bus.call = 1; bus.redirect_pc = 10'h100;
    ras_m.push_back(exp_addr + STEP);
    exp_addr = 10'h100; exp_q.push_back(exp_addr);
    step(seen);
    bus.redirect_en = 0; bus.call = 0;
    got = exp_q.pop_front();
    n_compared++;
    if (!seen || bus.addr !== got || bus.ras_empty !== 1'b0) begin
      n_mismatched++; $display("FAIL call_100: got %h empty %b expected %h/0", bus.addr, bus.ras_empty, got);
    end
    bus.ret = 1;
    exp_addr = ras_m.pop_back(); exp_q.push_back(exp_addr);
    step(seen);
    got = exp_q.pop_front();
    n_compared++;
    if (!seen || bus.addr !== got) begin n_mismatched++; $display("FAIL ret_pop: got %h expected %h", bus.addr, got); end
    exp_addr = exp_addr + STEP; exp_q.push_back(exp_addr);
    step(seen);
    bus.ret = 0;
    got = exp_q.pop_front();
    n_compared++;
    if (!seen || bus.addr !== got || flags() !== 4'b0011) begin
      n_mismatched++; $display("FAIL ret_empty: got %h flags %b expected %h/0011", bus.addr, flags(), got);
    end
    bus.clr_err = 1;
    @(negedge clk);
    bus.clr_err = 0;
    n_compared++;
    if (flags() !== 4'b0001) begin n_mismatched++; $display("FAIL clr_err: got %b expected 0001", flags()); end
    bus.call = 1;
    exp_addr = exp_addr + STEP; exp_q.push_back(exp_addr);
    step(seen);
    bus.call = 0;
    got = exp_q.pop_front();
    n_compared++;
    if (!seen || bus.addr !== got || flags() !== 4'b0001) begin
      n_mismatched++; $display("FAIL call_alone: got %h flags %b expected %h/0001", bus.addr, flags(), got);
    end
  endtask

  task automatic test_ras_overflow();
    bit seen, exp_ovf, exp_unf;
    logic [ADDR_W-1:0] got;
    logic [ADDR_W-1:0] tgt [5];
    tgt = '{10'h100, 10'h200, 10'h300, 10'h380, 10'h3C0};
    rst = 1;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    exp_addr = '0;
    ras_m.delete();
    exp_ovf = 0;
    for (int i = 0; i < 5; i++) begin
      if (ras_m.size() == 4) begin ras_m.delete(0); exp_ovf = 1; end
      ras_m.push_back(exp_addr + STEP);
      exp_addr = tgt[i]; exp_q.push_back(exp_addr);
      bus.redirect_en = 1; bus.call = 1; bus.redirect_pc = tgt[i];
      step(seen);
      bus.redirect_en = 0; bus.call = 0;
      got = exp_q.pop_front();
      n_compared++;
      if (!seen || bus.addr !== got || bus.ras_ovf !== exp_ovf) begin
        n_mismatched++; $display("FAIL ovf_call[%0d]: got %h ovf %b expected %h/%b", i, bus.addr, bus.ras_ovf, got, exp_ovf);
      end
    end
    exp_unf = 0;
    for (int i = 0; i < 5; i++) begin
      if (ras_m.size() > 0) exp_addr = ras_m.pop_back();
      else begin exp_addr = exp_addr + STEP; exp_unf = 1; end
      exp_q.push_back(exp_addr);
      bus.ret = 1;
      step(seen);
      bus.ret = 0;
      got = exp_q.pop_front();
      n_compared++;
      if (!seen || bus.addr !== got || bus.ras_unf !== exp_unf) begin
        n_mismatched++; $display("FAIL unf_ret[%0d]: got %h unf %b expected %h/%b", i, bus.addr, bus.ras_unf, got, exp_unf);
      end
    end
    n_compared++;
    if (flags() !== 4'b0111) begin n_mismatched++; $display("FAIL ras_end_flags: got %b expected 0111", flags()); end
  endtask

  task automatic test_misalign_reset();
    bit seen;
    int n_adv;
    logic [ADDR_W-1:0] got;
    bus.clr_err = 1;
    @(negedge clk);
    bus.clr_err = 0;
    bus.redirect_en = 1; bus.call = 1; bus.redirect_pc = 10'h103;
    exp_addr = 10'h100; exp_q.push_back(exp_addr);
    step(seen);
    bus.redirect_en = 0; bus.call = 0;
    got = exp_q.pop_front();
    n_compared++;
    if (!seen || bus.addr !== got || flags() !== 4'b1000) begin
      n_mismatched++; $display("FAIL misalign: got %h flags %b expected %h/1000", bus.addr, flags(), got);
    end
    bus.stall = 1; bus.nxt = 1;
    repeat (2) @(negedge clk);
    #2 rst = 1;
    #1;
    n_compared++;
    if (bus.addr !== 10'h000 || bus.start !== 1'b0 || flags() !== 4'b0001) begin
      n_mismatched++; $display("FAIL async_reset: got %h start %b flags %b expected 000/0/0001", bus.addr, bus.start, flags());
    end
    bus.stall = 0; bus.nxt = 0;
    @(negedge clk);
    rst = 0;
    n_adv = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.start === 1'b1) n_adv++;
    end
    n_compared++;
    if (n_adv != 0 || bus.addr !== 10'h000) begin
      n_mismatched++; $display("FAIL pending_cleared: advances %0d addr %h expected 0/000", n_adv, bus.addr);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_compared = 0;
    n_mismatched = 0;
    rst = 1;
    drive_idle();
    test_reset();
    test_step();
    test_run_wrap();
    test_stall_pending();
    test_call_ret();
    test_ras_overflow();
    test_misalign_reset();
    if (exp_q.size() != 0) begin
      n_compared++; n_mismatched++;
      $display("FAIL scoreboard_drain: %0d expected entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
